asmd_divider: RTL and testbench

- Sequential restoring divider built as an ASMD (algorithmic state machine with datapath). It performs the inverse of the team's shift-add ASMD multiplier and uses the same start/ready handshake.
- Computes one quotient bit per clock.
- Used wherever a product must be divided back, or where a ratio is needed without a combinational divider.

---
 rtl/asmd_divider.sv | 111 +++++++++++
 tb/tb_asmd_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/asmd_divider.sv
// Sequential restoring divider (ASMD): one quotient bit per clock,
// start/ready handshake, registered quotient/remainder/div_by_zero.
module asmd_divider #(
  parameter int word_length = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [word_length-1:0] dividend,
  input  logic [word_length-1:0] divisor,
  input  logic                   start,
  output logic [word_length-1:0] quotient,
  output logic [word_length-1:0] remainder,
  output logic                   div_by_zero,
  output logic                   ready
);

  localparam int W  = word_length;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [W:0]      a;
  logic [W-1:0]    q;
  logic [W-1:0]    d;
  logic [CW-1:0]   cnt;

  logic            load;
  logic            step;
  logic            done;
  logic [W:0]      a_sh;
  logic [W:0]      t;
  logic [W:0]      a_next;
  logic [W-1:0]    q_next;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == CW'(1)) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift {A,Q} left, trial-subtract; a negative trial keeps the shifted A.
  always_comb begin
    a_sh   = {a[W-1:0], q[W-1]};
    t      = a_sh - {1'b0, d};
    a_next = a_sh;
    q_next = {q[W-2:0], 1'b0};
    if (!t[W]) begin
      a_next = t;
      q_next = {q[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        a           <= '0;
        q           <= dividend;
        d           <= divisor;
        cnt         <= CW'(W);
        div_by_zero <= (divisor == '0);
      end
      if (step) begin
        a   <= a_next;
        q   <= q_next;
        cnt <= cnt - CW'(1);
      end
      if (done) begin
        quotient  <= q_next;
        remainder <= a_next[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_asmd_divider.sv
// Self-checking bench for asmd_divider: directed scenarios plus
// randomized operands against an arithmetic reference model.
module tb_asmd_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         start;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         ready;

  int n_cmp = 0;
  int n_err = 0;

  asmd_divider #(.word_length(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .dividend    (dividend),
    .divisor     (divisor),
    .start       (start),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic, divide by zero gives all ones / dividend.
  function automatic void ref_div(input int unsigned x, input int unsigned y,
                                  output int unsigned rq, output int unsigned rr);
    if (y == 0) begin
      rq = (1 << W) - 1;
      rr = x;
    end else begin
      rq = x / y;
      rr = x % y;
    end
  endfunction

  // Starts from a negedge, returns at the negedge where ready is seen high.
  task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y,
                         output int n);
    dividend = x;
    divisor  = y;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({ready, quotient, remainder, div_by_zero} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: rdy=%b q=%0d r=%0d dbz=%b want rdy=1 q=0 r=0 dbz=0",
               ready, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_nominal;
    int n;
    run_div(8'd100, 8'd7, n);
    n_cmp++;
    if (n !== W) begin
      n_err++;
      $display("FAIL nominal_latency: got %0d want %0d", n, W);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
      n_err++;
      $display("FAIL nominal: q=%0d r=%0d dbz=%b want 14 2 0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [W-1:0] ys [4] = '{8'd1, 8'd9, 8'd255, 8'd3};
    logic [W-1:0] eq [4] = '{8'd255, 8'd0, 8'd1, 8'd0};
    logic [W-1:0] er [4] = '{8'd0, 8'd5, 8'd0, 8'd0};
    int n;
    for (int i = 0; i < 4; i++) begin
      run_div(xs[i], ys[i], n);
      n_cmp++;
      if ({quotient, remainder} !== {eq[i], er[i]} || n !== W) begin
        n_err++;
        $display("FAIL boundary %0d/%0d: q=%0d r=%0d cyc=%0d want %0d %0d cyc=%0d",
                 xs[i], ys[i], quotient, remainder, n, eq[i], er[i], W);
      end
    end
  endtask

  task automatic test_div_zero;
    int n;
    run_div(8'd37, 8'd0, n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd37, 1'b1} || n !== W) begin
      n_err++;
      $display("FAIL div_zero: q=%0d r=%0d dbz=%b cyc=%0d want 255 37 1 cyc=%0d",
               quotient, remainder, div_by_zero, n, W);
    end
    run_div(8'd9, 8'd3, n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL div_zero_clear: q=%0d r=%0d dbz=%b want 3 0 0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_busy;
    int n;
    dividend = 8'd200;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd10;
    divisor  = 8'd2;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd77;
    divisor  = 8'd5;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if ({quotient, remainder} !== {8'd22, 8'd2} || n !== W - 2) begin
      n_err++;
      $display("FAIL busy: q=%0d r=%0d cyc=%0d want 22 2 cyc=%0d",
               quotient, remainder, n, W - 2);
    end
  endtask

  task automatic test_reset_midop;
    int n;
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({ready, quotient, remainder, div_by_zero} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_midop: rdy=%b q=%0d r=%0d dbz=%b want 1 0 0 0",
               ready, quotient, remainder, div_by_zero);
    end
    run_div(8'd100, 8'd7, n);
    n_cmp++;
    if ({quotient, remainder} !== {8'd14, 8'd2} || n !== W) begin
      n_err++;
      $display("FAIL after_reset: q=%0d r=%0d cyc=%0d want 14 2 cyc=%0d",
               quotient, remainder, n, W);
    end
  endtask

  task automatic test_random;
    int n;
    int unsigned x, y, rq, rr;
    for (int i = 0; i < 500; i++) begin
      x = $urandom_range(0, 255);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      ref_div(x, y, rq, rr);
      run_div(W'(x), W'(y), n);
      n_cmp++;
      if (quotient !== W'(rq) || remainder !== W'(rr) || n !== W ||
          div_by_zero !== (y == 0) ||
          (y != 0 && (quotient * y + remainder != x || remainder >= y))) begin
        n_err++;
        $display("FAIL random %0d/%0d: q=%0d r=%0d dbz=%b cyc=%0d want %0d %0d %b",
                 x, y, quotient, remainder, div_by_zero, n, rq, rr, y == 0);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    test_reset;
    test_nominal;
    test_back_to_back;
    test_div_zero;
    test_busy;
    test_reset_midop;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
